// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and defaults for the gpu result collector
package gpu_pkg;

   localparam int GPU_DATA_W = 8;
   localparam int GPU_PACK   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } coll_state_t;

   // Field order {data, cnt, last} is the flat layout stored in the collector FIFO.
   typedef struct packed {
      logic [GPU_DATA_W*GPU_PACK-1:0] data;
      logic [$clog2(GPU_PACK+1)-1:0]  cnt;
      logic                           last;
   } gpu_entry_t;

endpackage

// File: rtl/gpu_sync_fifo.sv
// rtl/gpu_sync_fifo.sv - synchronous FIFO with registered storage; head entry drives pop_data
module gpu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full/empty are judged on the pre-edge count, so a push into a full FIFO is refused even with a pop.
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/gpu_result_collector.sv
// rtl/gpu_result_collector.sv - packs gpu results into wide words, buffers them, flushes on busy fall
// Optional result_total counter port when GPU_RESULT_STATS_EN is defined.
module gpu_result_collector import gpu_pkg::*; #(
   parameter int DATA_W = GPU_DATA_W,
   parameter int PACK   = 4,
   parameter int DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         result_vld,
   output logic                         result_rdy,
   input  logic [DATA_W-1:0]            result_data,
   input  logic                         gpu_busy,
   output logic                         out_vld,
   input  logic                         out_rdy,
   output logic [DATA_W*PACK-1:0]       out_data,
   output logic [$clog2(PACK+1)-1:0]    out_cnt,
   output logic                         out_last,
   output logic                         done
`ifdef GPU_RESULT_STATS_EN
   ,
   output logic [15:0]                  result_total
`endif
);

   localparam int CNT_W   = $clog2(PACK+1);
   localparam int WORD_W  = DATA_W*PACK;
   localparam int ENTRY_W = WORD_W + CNT_W + 1;

   coll_state_t          state, state_nxt;
   logic [CNT_W-1:0]     lane_cnt;
   logic [WORD_W-1:0]    lanes;
   logic [WORD_W-1:0]    lanes_upd;
   logic                 busy_q;
   logic                 fall;
   logic                 last_lane;
   logic                 accept;
   logic                 push;
   logic [ENTRY_W-1:0]   push_entry;
   logic [ENTRY_W-1:0]   pop_entry;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [$clog2(DEPTH+1)-1:0] fifo_count;

   assign fall       = busy_q & ~gpu_busy;
   assign last_lane  = (lane_cnt == CNT_W'(PACK-1));
   // Backpressure only looks at FIFO occupancy, never at out_rdy.
   assign result_rdy = (state == RUN) && !(last_lane && fifo_full);
   assign accept     = result_vld & result_rdy;

   always_comb begin
      state_nxt  = state;
      push       = 1'b0;
      push_entry = '0;
      done       = 1'b0;
      lanes_upd  = lanes;
      lanes_upd[int'(lane_cnt)*DATA_W +: DATA_W] = result_data;
      case (state)
         IDLE: if (gpu_busy) state_nxt = RUN;
         RUN: begin
            if (accept && last_lane) begin
               push       = 1'b1;
               push_entry = {lanes_upd, CNT_W'(PACK), 1'b0};
            end
            if (fall) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (!fifo_full) begin
               push       = 1'b1;
               push_entry = {lanes, lane_cnt, 1'b1};
               state_nxt  = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_count == '0) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lane_cnt <= '0;
         lanes    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= gpu_busy;
         case (state)
            IDLE: begin
               if (gpu_busy) begin
                  lane_cnt <= '0;
                  lanes    <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  if (last_lane) begin
                     lane_cnt <= '0;
                     lanes    <= '0;
                  end else begin
                     lane_cnt <= lane_cnt + CNT_W'(1);
                     lanes    <= lanes_upd;
                  end
               end
            end
            FLUSH: begin
               if (!fifo_full) begin
                  lane_cnt <= '0;
                  lanes    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   gpu_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (out_vld & out_rdy),
      .pop_data  (pop_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_vld = ~fifo_empty;
   assign {out_data, out_cnt, out_last} = pop_entry;

`ifdef GPU_RESULT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_total <= '0;
      end else if (state == IDLE && gpu_busy) begin
         result_total <= '0;
      end else if (accept && result_total != 16'hFFFF) begin
         result_total <= result_total + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gpu_result_collector.sv
// tb/tb_gpu_result_collector.sv - randomized self-checking bench with a queue-based reference model
module tb_gpu_result_collector;

   localparam int DATA_W = 8;
   localparam int PACK   = 4;
   localparam int DEPTH  = 8;

   typedef struct {
      logic [31:0] data;
      int          cnt;
      bit          last;
   } word_t;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FLUSH = 2;
   localparam int M_DRAIN = 3;

   logic        clk;
   logic        rst_n;
   logic        result_vld;
   logic        result_rdy;
   logic [7:0]  result_data;
   logic        gpu_busy;
   logic        out_vld;
   logic        out_rdy;
   logic [31:0] out_data;
   logic [2:0]  out_cnt;
   logic        out_last;
   logic        done;
`ifdef GPU_RESULT_STATS_EN
   logic [15:0] result_total;
`endif

   int checks = 0;
   int errors = 0;
   int rdy_mode = 1;

   int          m_mode;
   logic [7:0]  m_part[$];
   word_t       m_q[$];
   bit          m_busy_q;
   logic [15:0] m_total;
   word_t       log_q[$];

   gpu_result_collector #(
      .DATA_W (DATA_W),
      .PACK   (PACK),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .result_vld  (result_vld),
      .result_rdy  (result_rdy),
      .result_data (result_data),
      .gpu_busy    (gpu_busy),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_data    (out_data),
      .out_cnt     (out_cnt),
      .out_last    (out_last),
      .done        (done)
`ifdef GPU_RESULT_STATS_EN
      ,
      .result_total (result_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_rdy();
      return (m_mode == M_RUN) && !(m_part.size() == PACK-1 && m_q.size() == DEPTH);
   endfunction

   function automatic word_t mk_word(input bit last);
      word_t w;
      w.data = '0;
      foreach (m_part[i]) w.data = w.data | (32'(m_part[i]) << (8*i));
      w.cnt  = m_part.size();
      w.last = last;
      return w;
   endfunction

   // Reference model: results collected in a queue, packed words in an unbounded queue capped at DEPTH.
   always @(posedge clk or negedge rst_n) begin
      int  pre;
      bit  pop;
      bit  fall;
      if (!rst_n) begin
         m_mode   = M_IDLE;
         m_part.delete();
         m_q.delete();
         m_busy_q = 1'b0;
         m_total  = '0;
      end else begin
         pre  = m_q.size();
         pop  = (pre != 0) && out_rdy;
         fall = m_busy_q && !gpu_busy;
         case (m_mode)
            M_IDLE: if (gpu_busy) begin
               m_mode  = M_RUN;
               m_part.delete();
               m_total = '0;
            end
            M_RUN: begin
               if (result_vld && exp_rdy()) begin
                  m_part.push_back(result_data);
                  if (m_total != 16'hFFFF) m_total = m_total + 16'd1;
                  if (m_part.size() == PACK) begin
                     m_q.push_back(mk_word(1'b0));
                     m_part.delete();
                  end
               end
               if (fall) m_mode = M_FLUSH;
            end
            M_FLUSH: if (pre < DEPTH) begin
               m_q.push_back(mk_word(1'b1));
               m_part.delete();
               m_mode = M_DRAIN;
            end
            default: if (pre == 0) m_mode = M_IDLE;
         endcase
         if (pop) void'(m_q.pop_front());
         m_busy_q = gpu_busy;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("result_rdy", result_rdy, exp_rdy());
         chk("out_vld", out_vld, m_q.size() != 0);
         chk("done", done, m_mode == M_DRAIN && m_q.size() == 0);
         if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0].data);
            chk("out_cnt", out_cnt, m_q[0].cnt);
            chk("out_last", out_last, m_q[0].last);
         end
`ifdef GPU_RESULT_STATS_EN
         chk("result_total", result_total, m_total);
`endif
         if (out_vld && out_rdy) log_q.push_back('{out_data, int'(out_cnt), out_last});
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0)      out_rdy = 1'b0;
      else if (rdy_mode == 1) out_rdy = 1'b1;
      else                    out_rdy = 1'($urandom_range(0, 1));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      int n = 0;
      bit ok = 1'b0;
      result_vld  = 1'b1;
      result_data = d;
      do begin
         @(negedge clk);
         n++;
         ok = result_rdy;
         tick();
      end while (!ok && n < 300);
      result_vld = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < limit) begin
         @(negedge clk);
         n++;
         seen = done;
      end
      chk("done_seen", seen, 1);
      tick();
   endtask

   task automatic check_word(input string name, input int idx, input logic [31:0] d, input int c, input bit l);
      if (idx < log_q.size()) begin
         chk({name, "_data"}, log_q[idx].data, d);
         chk({name, "_cnt"}, log_q[idx].cnt, c);
         chk({name, "_last"}, log_q[idx].last, l);
      end else begin
         chk({name, "_missing"}, idx, log_q.size());
      end
   endtask

   initial begin
      int acc;
      bit got;
      int n;
      rst_n       = 1'b0;
      result_vld  = 1'b0;
      result_data = '0;
      gpu_busy    = 1'b0;
      out_rdy     = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_result_rdy", result_rdy, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_done", done, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Two full words then the empty terminator
      log_q.delete();
      rdy_mode = 1;
      gpu_busy = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) send(8'(i));
      gpu_busy = 1'b0;
      wait_done(100);
      chk("full_nwords", log_q.size(), 3);
      check_word("full_w0", 0, 32'h04030201, 4, 1'b0);
      check_word("full_w1", 1, 32'h08070605, 4, 1'b0);
      check_word("full_term", 2, 32'h0, 0, 1'b1);

      // Partial flush
      log_q.delete();
      gpu_busy = 1'b1;
      tick();
      send(8'hA0);
      send(8'hA1);
      send(8'hA2);
      gpu_busy = 1'b0;
      wait_done(100);
      chk("part_nwords", log_q.size(), 1);
      check_word("part_w0", 0, 32'h00A2A1A0, 3, 1'b1);

      // Backpressure: FIFO fills, stalls on the fourth lane of the ninth word
      log_q.delete();
      rdy_mode = 0;
      gpu_busy = 1'b1;
      tick();
      acc = 0;
      for (int c = 0; c < 60; c++) begin
         result_vld  = 1'b1;
         result_data = 8'(acc + 1);
         @(negedge clk);
         got = result_rdy;
         tick();
         if (got) acc++;
      end
      result_vld = 1'b0;
      chk("bp_accepted", acc, 35);
      rdy_mode = 1;
      while (acc < 40) begin
         send(8'(acc + 1));
         acc++;
      end
      gpu_busy = 1'b0;
      wait_done(200);
      chk("bp_nwords", log_q.size(), 11);
      check_word("bp_w0", 0, 32'h04030201, 4, 1'b0);
      check_word("bp_w9", 9, 32'h28272625, 4, 1'b0);
      check_word("bp_term", 10, 32'h0, 0, 1'b1);

      // Result accepted in the same cycle busy falls
      log_q.delete();
      gpu_busy = 1'b1;
      tick();
      send(8'h54);
      result_vld  = 1'b1;
      result_data = 8'h55;
      gpu_busy    = 1'b0;
      tick();
      result_vld = 1'b0;
      wait_done(100);
      chk("fall_nwords", log_q.size(), 1);
      check_word("fall_w0", 0, 32'h00005554, 2, 1'b1);

      // Async reset while draining three queued words
      rdy_mode = 0;
      gpu_busy = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) send(8'(8'hC0 + i));
      gpu_busy = 1'b0;
      repeat (3) tick();
      chk("pre_rst_out_vld", out_vld, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_out_vld", out_vld, 0);
      chk("async_done", done, 0);
      chk("async_out_cnt", out_cnt, 0);
      tick();
      rst_n    = 1'b1;
      rdy_mode = 1;
      tick();
      chk("post_rst_rdy", result_rdy, 0);
      chk("post_rst_vld", out_vld, 0);

      // Randomized runs
      for (int r = 0; r < 40; r++) begin
         rdy_mode = (r % 4 == 0) ? 1 : 2;
         gpu_busy = 1'b1;
         tick();
         n = $urandom_range(0, 30);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (i == n-1 && $urandom_range(0, 1) == 1) begin
               result_vld  = 1'b1;
               result_data = 8'($urandom);
               gpu_busy    = 1'b0;
               tick();
               result_vld = 1'b0;
            end else begin
               send(8'($urandom));
            end
         end
         gpu_busy = 1'b0;
         wait_done(1000);
      end
      rdy_mode = 1;

`ifdef GPU_RESULT_STATS_EN
      gpu_busy = 1'b1;
      tick();
      result_vld = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         result_data = 8'(i);
         tick();
      end
      result_vld = 1'b0;
      chk("stats_sat", result_total, 16'hFFFF);
      gpu_busy = 1'b0;
      wait_done(200);
      chk("stats_hold", result_total, 16'hFFFF);
      gpu_busy = 1'b1;
      tick();
      chk("stats_clear", result_total, 0);
      gpu_busy = 1'b0;
      wait_done(200);
`endif

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpu_result_collector.md
Name: gpu_result_collector

Overview:
- Downstream neighbour of gpu_top. Consumes the result_vld/result_rdy/result_data stream and packs PACK consecutive results into one wide word.
- Buffers packed words in a small FIFO and presents them to the host on a valid/ready port.
- When gpu busy falls, it flushes any partial word marked last, waits for the FIFO to drain, then pulses done.

Parameters:
- DATA_W, 8, width of one gpu result.
- PACK, 4, results per output word (≥2).
- DEPTH, 8, FIFO depth in packed words (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- result_vld  in  1  gpu result valid.
- result_rdy  out  1  collector ready for a result.
- result_data  in  DATA_W  gpu result.
- gpu_busy  in  1  gpu_top busy.
- out_vld  out  1  packed word valid.
- out_rdy  in  1  host ready.
- out_data  out  DATA_W*PACK  packed word; lane 0 in LSBs, the first result lands in lane 0.
- out_cnt  out  $clog2(PACK+1)  number of valid lanes in out_data.
- out_last  out  1  final word of the run.
- done  out  1  one-cycle pulse when a run has fully drained.

Behaviour:
- Reset (async assert, sync release): state=IDLE, lane_cnt=0, FIFO empty, busy_q=0. All outputs are 0: result_rdy, out_vld, out_data, out_cnt, out_last, done.
- busy_q is a registered copy of gpu_busy. fall = busy_q & ~gpu_busy.
- State IDLE:
  - result_rdy=0.
  - gpu_busy=1 → RUN; lane_cnt cleared.
- State RUN:
  - result_rdy = ~(lane_cnt==PACK-1 & fifo_full). It does not depend on out_rdy, so there is no combinational path out_rdy→result_rdy.
  - Accept (vld&rdy): write the lane at index lane_cnt and increment it. On the PACK-th lane, push {data, cnt=PACK, last=0} into the FIFO in the same cycle and reset lane_cnt to 0.
  - On fall → FLUSH. A result accepted in the fall cycle is still packed.
- State FLUSH:
  - result_rdy=0. When the FIFO is not full, push {partial lanes, cnt=lane_cnt, last=1}, then go to DRAIN.
  - A lane_cnt=0 terminator (cnt=0, last=1, data=0) is always pushed, so the host always sees last.
  - Unused lanes are zero.
- State DRAIN:
  - result_rdy=0. When the FIFO is empty and no push is pending: done=1 for one cycle, then IDLE.
  - gpu_busy rising during FLUSH/DRAIN is ignored until IDLE is reached.
- FIFO:
  - Synchronous, registered storage; out_* come from the head entry. out_vld = ~empty.
  - Pop on out_vld&out_rdy.
  - Push-to-out_vld latency is 1 cycle (data registered at edge N is visible after edge N).
  - Simultaneous push and pop when full: the push is blocked (full is evaluated before the pop).
  - Simultaneous push and pop when empty: legal; count unchanged only if both occur with count ≥1. When empty, only the push takes effect.
  - Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH+1).
- Hold: out_data, out_cnt and out_last are stable while out_vld & ~out_rdy.
- Reset mid-run: all partial and buffered data is discarded immediately and no done is produced.

Optional Feature:
- Macro: GPU_RESULT_STATS_EN.
- Defined: adds output port result_total (16 bits), counting accepted results.
  - Cleared on the IDLE→RUN transition.
  - Saturates at 16'hFFFF and holds its value after done.
  - Reset value is 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package gpu_pkg holds:
  - the collector state enum (IDLE, RUN, FLUSH, DRAIN), 2 bits;
  - GPU_DATA_W=8 as a shared default;
  - the packed-word entry struct {data, cnt, last}.
- Sub-module gpu_sync_fifo (parameters WIDTH, DEPTH) carries the entry struct: push/pop/full/empty/count. This sub-module is natural and reusable.

Test Plan:
- Full words: PACK=4, busy=1, send 0x01..0x08 with out_rdy=1, drop busy. Expect two words, 0x04030201 and 0x08070605 with cnt=4, last=0, then terminator cnt=0, last=1, then done pulse.
- Partial flush: send 0xA0,0xA1,0xA2 then drop busy. Expect a single word 0x00A2A1A0 with cnt=3, last=1, then done one cycle after the pop.
- Backpressure: out_rdy=0, stream 40 results. Expect result_rdy to drop after 8 words plus 3 lanes (35 accepted). Raise out_rdy and expect all 10 words in order plus terminator; no loss or duplication.
- Fall-cycle accept: result_vld=1 with 0x55 in the same cycle busy falls, lane_cnt=1. Expect 0x55 packed: flush word cnt=2.
- Async reset mid-DRAIN with 3 words queued: expect out_vld=0 and done=0 immediately with no clock, and the IDLE state after release.
- With GPU_RESULT_STATS_EN, run 70000 results: expect result_total=16'hFFFF, then 0 on the next IDLE→RUN.
